// File: rtl/psram_engine_pkg.sv
// ============================================================================
// psram_engine_pkg
// State encoding, phase lengths, pad-enable codes and byte-order helpers
// shared by the PSRAM serial transfer engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package psram_engine_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [5:0] CMD_SER   = 6'd8;
  localparam logic [5:0] CMD_QUAD  = 6'd2;
  localparam logic [5:0] ADDR_SER  = 6'd24;
  localparam logic [5:0] ADDR_QUAD = 6'd6;

  localparam logic [3:0] OE_OFF  = 4'b0000;
  localparam logic [3:0] OE_SER  = 4'b0001;
  localparam logic [3:0] OE_QUAD = 4'b1111;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Received bytes land MSB-first in the low bits; put byte 0 at [7:0].
  function automatic logic [31:0] rd_format(input logic [31:0] r, input logic [2:0] sz);
    case (sz)
      3'd1:    rd_format = {24'h0, r[7:0]};
      3'd2:    rd_format = {16'h0, r[7:0], r[15:8]};
      default: rd_format = bswap32(r);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/psram_engine_shifter.sv
// ============================================================================
// psram_engine_shifter
// 32-bit shift register: presents the outgoing bits at the top and assembles
// incoming pad data at the bottom, one or four bits per sck clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module psram_engine_shifter
  import psram_engine_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        shift_i,
  input  logic        quad_i,
  input  logic [3:0]  din_i,
  output logic [3:0]  msb_o,
  output logic [31:0] shifted_o
);

  logic [31:0] sh_q, sh_d;

  // Serial reads arrive on pad 1.
  assign shifted_o = quad_i ? {sh_q[27:0], din_i} : {sh_q[30:0], din_i[1]};
  assign msb_o     = sh_q[31:28];

  always_comb begin
    sh_d = sh_q;
    if (load_i)
      sh_d = load_val_i;
    else if (shift_i)
      sh_d = shifted_o;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      sh_q <= '0;
    else
      sh_q <= sh_d;
  end

endmodule

`default_nettype wire

// File: rtl/psram_qspi_engine.sv
// ============================================================================
// psram_qspi_engine
// Serialises one latched PSRAM transaction (command, address, wait, data)
// in SPI / QSPI / QPI modes. Option: PSRAM_ENGINE_RD_SAMPLE_DELAY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module psram_qspi_engine
  import psram_engine_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [31:0] data_i,
  input  logic [2:0]  size,
  input  logic [7:0]  cmd,
  input  logic        rd_wr,
  input  logic [3:0]  wait_states,
  input  logic        qspi,
  input  logic        qpi,
  input  logic        short_cmd,
  output logic [31:0] data_o,
  output logic        done,
  output logic        sck,
  output logic        ce_n,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic [3:0]  douten
);

  logic [2:0]  state_q, state_d;
  logic        half_q, half_d, sck_q, sck_d, ce_n_q, ce_n_d, done_q, done_d;
  logic        pend_q, pend_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  oe_q, oe_d;
  logic [31:0] data_q, data_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  ws_q, ws_d;
  logic        rd_q, rd_d, qspi_q, qspi_d, qpi_q, qpi_d, short_q, short_d;

  logic        w_load, w_shift, w_adv, w_qany, w_quad, w_defer;
  logic [31:0] w_load_val, w_shifted;
  logic [3:0]  w_msb;
  logic [2:0]  w_nxt;
  logic [5:0]  w_wait_len, w_data_len;

  assign w_qany     = qspi_q | qpi_q;
  assign w_quad     = (state_q == S_CMD) ? qpi_q : w_qany;
  assign w_wait_len = (rd_q & w_qany) ? {2'b00, ws_q} : 6'd0;
  assign w_data_len = w_qany ? {2'b00, size_q, 1'b0} : {size_q, 3'b000};

`ifdef PSRAM_ENGINE_RD_SAMPLE_DELAY_EN
  // Read bits are captured one HCLK after the sck high half ends.
  assign w_defer = (state_q == S_DATA) & rd_q;
`else
  assign w_defer = 1'b0;
`endif

  always_comb begin
    case (state_q)
      S_CMD:   w_nxt = short_q ? S_FINISH : S_ADDR;
      S_ADDR:  w_nxt = (w_wait_len != 6'd0) ? S_WAIT : S_DATA;
      S_WAIT:  w_nxt = S_DATA;
      default: w_nxt = S_FINISH;
    endcase
  end

  always_comb begin
    state_d = state_q;  half_d = half_q;  sck_d = sck_q;  ce_n_d = ce_n_q;
    cnt_d   = cnt_q;    oe_d   = oe_q;    data_d = data_q; pend_d = pend_q;
    done_d  = 1'b0;
    addr_d  = addr_q;   wdata_d = wdata_q; size_d = size_q; ws_d = ws_q;
    rd_d    = rd_q;     qspi_d  = qspi_q;  qpi_d  = qpi_q;  short_d = short_q;
    w_load  = 1'b0;     w_load_val = '0;   w_shift = 1'b0;  w_adv = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        addr_d  = addr;   wdata_d = data_i;  rd_d = rd_wr;  ws_d = wait_states;
        qspi_d  = qspi;   qpi_d   = qpi;     short_d = short_cmd;
        size_d  = (size == 3'd1 || size == 3'd2) ? size : 3'd4;
        state_d = S_CMD;  ce_n_d  = 1'b0;    half_d = 1'b0;  sck_d = 1'b0;
        cnt_d   = qpi ? CMD_QUAD : CMD_SER;
        oe_d    = qpi ? OE_QUAD : OE_SER;
        w_load  = 1'b1;   w_load_val = {cmd, 24'h0};
      end
      S_FINISH: state_d = S_IDLE;
      default: begin
        if (!half_q) begin
          if (pend_q) begin
            w_shift = 1'b1;
            pend_d  = 1'b0;
          end
          // A zero count here is the extra delayed-sample cycle after the last read clock.
          if (cnt_q == 6'd0)
            w_adv = 1'b1;
          else begin
            sck_d  = 1'b1;
            half_d = 1'b1;
          end
        end else begin
          sck_d  = 1'b0;
          half_d = 1'b0;
          if (w_defer) pend_d = 1'b1;
          else         w_shift = 1'b1;
          if (cnt_q != 6'd1) cnt_d = cnt_q - 6'd1;
          else if (w_defer)  cnt_d = 6'd0;
          else               w_adv = 1'b1;
        end
      end
    endcase

    if (w_adv) begin
      state_d = w_nxt;
      case (w_nxt)
        S_ADDR: begin
          cnt_d  = w_qany ? ADDR_QUAD : ADDR_SER;
          oe_d   = w_qany ? OE_QUAD : OE_SER;
          w_load = 1'b1;  w_load_val = {addr_q, 8'h0};
        end
        S_WAIT: begin
          cnt_d = w_wait_len;
          oe_d  = OE_OFF;
        end
        S_DATA: begin
          cnt_d  = w_data_len;
          oe_d   = rd_q ? OE_OFF : (w_qany ? OE_QUAD : OE_SER);
          w_load = 1'b1;  w_load_val = rd_q ? 32'h0 : bswap32(wdata_q);
        end
        default: begin
          ce_n_d = 1'b1;
          oe_d   = OE_OFF;
          done_d = 1'b1;
          if (state_q == S_DATA && rd_q)
            data_d = rd_format(w_shifted, size_q);
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE; half_q <= 1'b0; sck_q <= 1'b0; ce_n_q <= 1'b1;
      cnt_q   <= '0;     oe_q   <= OE_OFF; data_q <= '0; done_q <= 1'b0;
      pend_q  <= 1'b0;   addr_q <= '0;   wdata_q <= '0; size_q <= '0;
      ws_q    <= '0;     rd_q   <= 1'b0; qspi_q <= 1'b0; qpi_q <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d; half_q <= half_d; sck_q <= sck_d; ce_n_q <= ce_n_d;
      cnt_q   <= cnt_d;   oe_q   <= oe_d;   data_q <= data_d; done_q <= done_d;
      pend_q  <= pend_d;  addr_q <= addr_d; wdata_q <= wdata_d; size_q <= size_d;
      ws_q    <= ws_d;    rd_q   <= rd_d;   qspi_q <= qspi_d; qpi_q <= qpi_d;
      short_q <= short_d;
    end
  end

  psram_engine_shifter u_shifter (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .shift_i    (w_shift),
    .quad_i     (w_quad),
    .din_i      (din),
    .msb_o      (w_msb),
    .shifted_o  (w_shifted)
  );

  assign dout   = oe_q & (oe_q[3] ? w_msb : {3'b000, w_msb[3]});
  assign douten = oe_q;
  assign sck    = sck_q;
  assign ce_n   = ce_n_q;
  assign done   = done_q;
  assign data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_psram_qspi_engine.sv
// ============================================================================
// tb_psram_qspi_engine
// Randomised scoreboard bench with a pin-level PSRAM model for the engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_psram_qspi_engine;

`ifdef PSRAM_ENGINE_RD_SAMPLE_DELAY_EN
  localparam int RD_XTRA = 1;
`else
  localparam int RD_XTRA = 0;
`endif

  logic        HCLK = 1'b0, HRESETn = 1'b1, start = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] data_i = '0;
  logic [2:0]  size = '0;
  logic [7:0]  cmd = '0;
  logic        rd_wr = 1'b0, qspi = 1'b0, qpi = 1'b0, short_cmd = 1'b0;
  logic [3:0]  wait_states = '0, din = '0;
  logic [31:0] data_o;
  logic        done, sck, ce_n;
  logic [3:0]  dout, douten;

  typedef struct {
    bit rd, qspi, qpi, shrt, abort;
    bit [2:0] size; bit [3:0] ws; bit [7:0] cmd; bit [23:0] addr;
    bit [31:0] wdata, rbytes;
  } txn_t;
  typedef struct { bit [31:0] data; int cyc; } exp_t;

  txn_t mdl_q[$];
  exp_t sb_q[$];
  int n_checks = 0, n_pass = 0, cyc = 0;
  bit [31:0] last_rd = '0;

  psram_qspi_engine dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .addr(addr), .data_i(data_i),
    .size(size), .cmd(cmd), .rd_wr(rd_wr), .wait_states(wait_states), .qspi(qspi),
    .qpi(qpi), .short_cmd(short_cmd), .data_o(data_o), .done(done), .sck(sck),
    .ce_n(ce_n), .din(din), .dout(dout), .douten(douten)
  );

  initial forever #5 HCLK = ~HCLK;
  initial forever begin @(posedge HCLK); cyc++; end

  task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic int eff_size(input bit [2:0] s);
    return (s == 3'd1 || s == 3'd2) ? int'(s) : 4;
  endfunction

  function automatic int n_clocks(input txn_t t);
    bit q = t.qspi | t.qpi;
    int n = t.qpi ? 2 : 8;
    if (t.shrt) return n;
    n += q ? 6 : 24;
    if (t.rd && q) n += int'(t.ws);
    n += eff_size(t.size) * (q ? 2 : 8);
    return n;
  endfunction

  function automatic bit [31:0] rd_expect(input txn_t t);
    bit [31:0] r = '0;
    for (int i = 0; i < eff_size(t.size); i++) r[8*i +: 8] = t.rbytes[8*i +: 8];
    return r;
  endfunction

  function automatic txn_t mk(input bit rd, input bit qs, input bit qp, input bit sh,
                              input bit [2:0] sz, input bit [3:0] ws, input bit [7:0] c,
                              input bit [23:0] a, input bit [31:0] wd, input bit [31:0] rb);
    txn_t t;
    t.rd = rd; t.qspi = qs; t.qpi = qp; t.shrt = sh; t.abort = 1'b0; t.size = sz;
    t.ws = ws; t.cmd = c; t.addr = a; t.wdata = wd; t.rbytes = rb;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int m = $urandom_range(2, 0);
    return mk(1'($urandom), (m == 1) || (m == 2 && $urandom_range(1, 0) == 1), m == 2,
              $urandom_range(5, 0) == 0, 3'($urandom), 4'($urandom), 8'($urandom),
              24'($urandom), $urandom, $urandom);
  endfunction

  // Register the transaction with the pin model and the expected completion.
  function automatic void plan(input txn_t t, input int t0);
    exp_t e;
    mdl_q.push_back(t);
    if (!t.abort) begin
      if (t.rd && !t.shrt) last_rd = rd_expect(t);
      e.data = last_rd;
      e.cyc  = t0 + 2 * n_clocks(t) + 1 + ((t.rd && !t.shrt) ? RD_XTRA : 0);
      sb_q.push_back(e);
    end
  endfunction

  task automatic drive(input txn_t t);
    start = 1'b1; cmd = t.cmd; addr = t.addr; data_i = t.wdata; size = t.size;
    rd_wr = t.rd; wait_states = t.ws; qspi = t.qspi; qpi = t.qpi; short_cmd = t.shrt;
  endtask

  task automatic scramble();
    start = 1'b0; cmd = 8'($urandom); addr = 24'($urandom); data_i = $urandom;
    size = 3'($urandom); rd_wr = 1'($urandom); wait_states = 4'($urandom);
    qspi = 1'($urandom); qpi = 1'($urandom); short_cmd = 1'($urandom);
  endtask

  task automatic issue(input txn_t t);
    drive(t);
    plan(t, cyc);
    @(posedge HCLK); #1;
    scramble();
  endtask

  task automatic wait_done();
    int b = 0;
    while (sb_q.size() != 0 && b < 600) begin @(negedge HCLK); b++; end
    if (b >= 600) begin
      check("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(posedge HCLK); #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && done) begin
        if (sb_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("data_o", data_o, e.data);
        end
      end
    end
  end

  // PSRAM pin model: decodes phases from the transaction, answers reads.
  initial begin
    txn_t t;
    int n, k, cl, al, wl, j;
    bit qd, oe_ok;
    logic [3:0] eo;
    longint unsigned ca, aa, wa, we;
    bit [7:0] by;
    forever begin
      @(negedge ce_n);
      if (mdl_q.size() == 0) begin
        check("ce_without_start", 1, 0);
        continue;
      end
      t  = mdl_q.pop_front();
      n  = n_clocks(t); k = 0; qd = t.qspi | t.qpi;
      cl = t.qpi ? 2 : 8;
      al = t.shrt ? 0 : (qd ? 6 : 24);
      wl = (t.rd && qd && !t.shrt) ? int'(t.ws) : 0;
      ca = 0; aa = 0; wa = 0; oe_ok = 1'b1;
      forever begin
        @(posedge sck or posedge ce_n);
        if (ce_n) break;
        #1;
        k++;
        din = 4'($urandom);
        if (k <= cl) begin
          eo = t.qpi ? 4'hF : 4'h1;
          ca = t.qpi ? ((ca << 4) | dout) : ((ca << 1) | dout[0]);
        end else if (k <= cl + al) begin
          eo = qd ? 4'hF : 4'h1;
          aa = qd ? ((aa << 4) | dout) : ((aa << 1) | dout[0]);
        end else if (k <= cl + al + wl) begin
          eo = 4'h0;
        end else begin
          j = k - cl - al - wl - 1;
          if (t.rd) begin
            eo = 4'h0;
            if (j < (qd ? 8 : 32)) begin
              by = t.rbytes[8*(qd ? j/2 : j/8) +: 8];
              if (qd) din = (j % 2 == 0) ? by[7:4] : by[3:0];
              else    din[1] = by[7 - j % 8];
            end
          end else begin
            eo = qd ? 4'hF : 4'h1;
            wa = qd ? ((wa << 4) | dout) : ((wa << 1) | dout[0]);
          end
        end
        if (douten !== eo || (eo == 4'h0 && dout !== 4'h0)) oe_ok = 1'b0;
      end
      if (!t.abort) begin
        check("sck_clocks", k, n);
        check("cmd_bits", ca, t.cmd);
        check("pad_enables", oe_ok, 1);
        if (!t.shrt) check("addr_bits", aa, t.addr);
        if (!t.rd && !t.shrt) begin
          we = 0;
          for (int i = 0; i < eff_size(t.size); i++) we = (we << 8) | t.wdata[8*i +: 8];
          check("write_bits", wa, we);
        end
      end
    end
  end

  initial begin
    txn_t t, u;
    int t0, b;
    #1 HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    check("rst_sck", sck, 0);       check("rst_ce_n", ce_n, 1);
    check("rst_dout", dout, 0);     check("rst_douten", douten, 0);
    check("rst_done", done, 0);     check("rst_data_o", data_o, 0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // SPI read, bytes 11 22 33 44
    issue(mk(1, 0, 0, 0, 3'd4, 4'd0, 8'h03, 24'h012345, 32'h0, 32'h44332211));
    wait_done();
    check("spi_read_word", data_o, 32'h44332211);

    // QPI read with 6 wait clocks
    issue(mk(1, 0, 1, 0, 3'd4, 4'd6, 8'hEB, 24'($urandom), 32'h0, $urandom));
    wait_done();

    // QSPI single-byte write
    issue(mk(0, 1, 0, 0, 3'd1, 4'd3, 8'h38, 24'($urandom), 32'hFFFF_FFA5, 32'h0));
    wait_done();

    // Short command must leave data_o untouched
    issue(mk(1, 0, 0, 1, 3'd4, 4'd0, 8'h35, 24'h0, 32'h0, $urandom));
    wait_done();

    // Start during DATA must be ignored
    t0 = cyc;
    issue(mk(0, 0, 0, 0, 3'd4, 4'd0, 8'h02, 24'($urandom), $urandom, 32'h0));
    while (cyc < t0 + 70) @(posedge HCLK);
    #1;
    drive(rand_txn());
    @(posedge HCLK); #1;
    scramble();
    wait_done();

    // Start held across the done cycle: accepted one cycle later
    issue(mk(0, 0, 1, 0, 3'd2, 4'd0, 8'h38, 24'($urandom), $urandom, 32'h0));
    b = 0;
    do begin @(negedge HCLK); b++; end while (done !== 1'b1 && b < 600);
    check("done_seen_for_b2b", done, 1);
    u = mk(1, 0, 0, 0, 3'd2, 4'd0, 8'h03, 24'($urandom), 32'h0, $urandom);
    drive(u);
    plan(u, cyc + 1);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    scramble();
    wait_done();

    // Reset in the middle of ADDR, during an sck high half
    t = mk(1, 0, 0, 0, 3'd4, 4'd0, 8'h03, 24'($urandom), 32'h0, $urandom);
    t.abort = 1'b1;
    t0 = cyc;
    issue(t);
    while (cyc < t0 + 20) @(negedge HCLK);
    check("sck_high_mid_addr", sck, 1);
    HRESETn = 1'b0;
    #1;
    check("async_rst_ce_n", ce_n, 1);
    check("async_rst_sck", sck, 0);
    check("async_rst_douten", douten, 0);
    last_rd = '0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (10) @(negedge HCLK);
    check("data_o_after_rst", data_o, last_rd);
    @(posedge HCLK); #1;

    for (int i = 0; i < 40; i++) begin
      issue(rand_txn());
      wait_done();
    end

    repeat (5) @(posedge HCLK);
    check("sb_drained", sb_q.size(), 0);
    check("model_drained", mdl_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
